// File: rtl/stack_arbiter.sv
// Two-requester round-robin arbiter that serialises push/pop commands onto an
// external stack, one 3-cycle transaction (grant, issue, complete) at a time.
module stack_arbiter #(
  parameter int unsigned DATA_WIDTH = 2,
  parameter int unsigned DEPTH      = 32
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [1:0]            REQ,
  input  logic [1:0]            OP,
  input  logic [DATA_WIDTH-1:0] WDATA0,
  input  logic [DATA_WIDTH-1:0] WDATA1,
  output logic [1:0]            GNT,
  output logic [1:0]            DONE,
  output logic                  ERR,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic [5:0]            LEVEL,
  output logic                  STK_PUSH,
  output logic                  STK_POP,
  output logic [DATA_WIDTH-1:0] STK_DIN,
  input  logic [DATA_WIDTH-1:0] STK_DOUT,
  input  logic                  STK_FULL,
  input  logic                  STK_EMPTY
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;

  state_e                state_q, state_d;
  logic                  last_q, last_d;
  logic                  win_q, win_d;
  logic                  op_q, op_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  legal_q, legal_d;
  logic [1:0]            gnt_q, gnt_d;
  logic [1:0]            done_q, done_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [5:0]            level_q, level_d;
  logic                  push_q, push_d;
  logic                  pop_q, pop_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic                  winner;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    win_d   = win_q;
    op_d    = op_q;
    data_d  = data_q;
    legal_d = legal_q;
    gnt_d   = '0;
    done_d  = '0;
    err_d   = 1'b0;
    rdata_d = rdata_q;
    level_d = level_q;
    push_d  = 1'b0;
    pop_d   = 1'b0;
    din_d   = din_q;
    winner  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (REQ != 2'b00) begin
          // Under contention the requester that did not win last time goes next.
          winner        = (REQ == 2'b11) ? ~last_q : REQ[1];
          gnt_d[winner] = 1'b1;
          last_d        = winner;
          win_d         = winner;
          op_d          = OP[winner];
          data_d        = winner ? WDATA1 : WDATA0;
          state_d       = ISSUE;
        end
      end
      ISSUE: begin
        legal_d = op_q ? ~STK_EMPTY : ~STK_FULL;
        push_d  = legal_d & ~op_q;
        pop_d   = legal_d & op_q;
        if (push_d) din_d = data_q;
        state_d = WAIT;
      end
      WAIT: begin
        done_d[win_q] = 1'b1;
        err_d         = ~legal_q;
        if (legal_q) begin
          if (!op_q) begin
            if (level_q < 6'(DEPTH)) level_d = level_q + 6'd1;
          end else begin
            if (level_q != 6'd0) level_d = level_q - 6'd1;
            rdata_d = STK_DOUT;
          end
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      win_q   <= 1'b0;
      op_q    <= 1'b0;
      data_q  <= '0;
      legal_q <= 1'b0;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      level_q <= '0;
      push_q  <= 1'b0;
      pop_q   <= 1'b0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      win_q   <= win_d;
      op_q    <= op_d;
      data_q  <= data_d;
      legal_q <= legal_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      level_q <= level_d;
      push_q  <= push_d;
      pop_q   <= pop_d;
      din_q   <= din_d;
    end
  end

  assign GNT      = gnt_q;
  assign DONE     = done_q;
  assign ERR      = err_q;
  assign RDATA    = rdata_q;
  assign LEVEL    = level_q;
  assign STK_PUSH = push_q;
  assign STK_POP  = pop_q;
  assign STK_DIN  = din_q;

endmodule

// File: tb/tb_stack_arbiter.sv
// Bench for stack_arbiter: a small stack drives the status/data inputs and a
// queue-based model predicts grants, completions, errors, read data and level.
module tb_stack_arbiter;
  localparam int DW    = 2;
  localparam int DEPTH = 32;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic [1:0]    REQ, OP;
  logic [DW-1:0] WDATA0, WDATA1;
  logic [1:0]    GNT, DONE;
  logic          ERR, STK_PUSH, STK_POP, STK_FULL, STK_EMPTY;
  logic [DW-1:0] RDATA, STK_DIN, STK_DOUT;
  logic [5:0]    LEVEL;

  stack_arbiter #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST_N(RST_N), .REQ(REQ), .OP(OP), .WDATA0(WDATA0), .WDATA1(WDATA1),
    .GNT(GNT), .DONE(DONE), .ERR(ERR), .RDATA(RDATA), .LEVEL(LEVEL),
    .STK_PUSH(STK_PUSH), .STK_POP(STK_POP), .STK_DIN(STK_DIN), .STK_DOUT(STK_DOUT),
    .STK_FULL(STK_FULL), .STK_EMPTY(STK_EMPTY)
  );

  always #5 CLK = ~CLK;

  // Attached stack: top-of-stack is visible combinationally, updates on the edge.
  logic [DW-1:0] mem [DEPTH];
  int            sp;
  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) sp <= 0;
    else if (STK_PUSH && sp < DEPTH) begin
      mem[sp] <= STK_DIN;
      sp      <= sp + 1;
    end else if (STK_POP && sp > 0) sp <= sp - 1;
  end
  assign STK_DOUT  = (sp > 0) ? mem[sp-1] : '0;
  assign STK_FULL  = (sp == DEPTH);
  assign STK_EMPTY = (sp == 0);

  logic [DW-1:0] mdl [$];
  bit            last_m;
  logic [DW-1:0] exp_rdata;
  int            checks   = 0;
  int            failures = 0;

  task automatic model_reset();
    mdl.delete();
    last_m    = 1'b1;
    exp_rdata = '0;
  endtask

  task automatic noise();
    REQ    = 2'($urandom);
    OP     = 2'($urandom);
    WDATA0 = DW'($urandom);
    WDATA1 = DW'($urandom);
  endtask

  task automatic run_txn(input logic [1:0] req, input logic [1:0] op,
                         input logic [DW-1:0] w0, input logic [DW-1:0] w1);
    bit            win, legal;
    logic          op_w;
    logic [DW-1:0] d_w;
    logic [1:0]    gexp;
    @(negedge CLK);
    REQ = req; OP = op; WDATA0 = w0; WDATA1 = w1;
    win  = (req == 2'b11) ? ~last_m : req[1];
    op_w = op[win];
    d_w  = win ? w1 : w0;
    gexp = win ? 2'b10 : 2'b01;
    @(posedge CLK); #1;
    checks++;
    if (GNT !== gexp) begin
      failures++; $display("FAIL grant: GNT=%b expected=%b (req=%b)", GNT, gexp, req);
    end
    last_m = win;
    legal  = op_w ? (mdl.size() > 0) : (mdl.size() < DEPTH);
    @(negedge CLK); noise();
    @(posedge CLK); #1;
    checks++;
    if ({STK_PUSH, STK_POP, GNT, DONE} !== {legal && !op_w, legal && op_w, 4'b0000}) begin
      failures++;
      $display("FAIL issue: push=%b pop=%b gnt=%b done=%b expected push=%b pop=%b",
               STK_PUSH, STK_POP, GNT, DONE, legal && !op_w, legal && op_w);
    end
    if (legal && !op_w) begin
      checks++;
      if (STK_DIN !== d_w) begin
        failures++; $display("FAIL stk_din: STK_DIN=%b expected=%b", STK_DIN, d_w);
      end
    end
    @(negedge CLK); noise();
    @(posedge CLK); #1;
    if (legal) begin
      if (!op_w) mdl.push_back(d_w);
      else       exp_rdata = mdl.pop_back();
    end
    checks++;
    if ({DONE, ERR, STK_PUSH, STK_POP, GNT} !== {gexp, !legal, 4'b0000}) begin
      failures++;
      $display("FAIL done: DONE=%b ERR=%b push=%b pop=%b gnt=%b expected DONE=%b ERR=%b",
               DONE, ERR, STK_PUSH, STK_POP, GNT, gexp, !legal);
    end
    checks++;
    if (RDATA !== exp_rdata) begin
      failures++; $display("FAIL rdata: RDATA=%b expected=%b", RDATA, exp_rdata);
    end
    checks++;
    if (LEVEL !== 6'(mdl.size())) begin
      failures++; $display("FAIL level: LEVEL=%0d expected=%0d", LEVEL, mdl.size());
    end
  endtask

  task automatic apply_reset();
    @(negedge CLK);
    REQ = '0; RST_N = 1'b0;
    model_reset();
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  task automatic test_reset();
    REQ = '0; OP = '0; WDATA0 = '0; WDATA1 = '0;
    RST_N = 1'b0;
    model_reset();
    #12;
    checks++;
    if ({GNT, DONE, ERR, STK_PUSH, STK_POP, RDATA, STK_DIN, LEVEL} !== '0) begin
      failures++;
      $display("FAIL reset: gnt=%b done=%b err=%b push=%b pop=%b rdata=%b din=%b level=%0d expected all 0",
               GNT, DONE, ERR, STK_PUSH, STK_POP, RDATA, STK_DIN, LEVEL);
    end
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  task automatic test_idle();
    @(negedge CLK); REQ = '0;
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK); #1;
      checks++;
      if ({GNT, DONE, STK_PUSH, STK_POP} !== 6'b0) begin
        failures++; $display("FAIL idle: GNT=%b DONE=%b push=%b pop=%b expected 0", GNT, DONE, STK_PUSH, STK_POP);
      end
    end
  endtask

  task automatic test_single_push();
    run_txn(2'b01, 2'b00, 2'b10, 2'b00);
  endtask

  task automatic test_push_pop_r1();
    run_txn(2'b10, 2'b00, 2'b00, 2'b11);
    run_txn(2'b10, 2'b10, 2'b01, 2'b00);
  endtask

  task automatic test_contention();
    for (int i = 0; i < 4; i++) run_txn(2'b11, 2'($urandom), DW'($urandom), DW'($urandom));
  endtask

  task automatic test_empty_pop();
    apply_reset();
    run_txn(2'b01, 2'b01, 2'b11, 2'b11);
  endtask

  task automatic test_fill();
    apply_reset();
    for (int i = 0; i < DEPTH + 1; i++)
      run_txn(2'($urandom_range(1, 3)), 2'b00, DW'($urandom), DW'($urandom));
    for (int i = 0; i < 3; i++)
      run_txn(2'($urandom_range(1, 3)), 2'b11, DW'($urandom), DW'($urandom));
  endtask

  task automatic test_random();
    for (int i = 0; i < 80; i++)
      run_txn(2'($urandom_range(1, 3)), 2'($urandom), DW'($urandom), DW'($urandom));
  endtask

  task automatic test_reset_mid();
    apply_reset();
    @(negedge CLK);
    REQ = 2'b01; OP = 2'b00; WDATA0 = 2'b01;
    @(posedge CLK); #1;
    @(negedge CLK); REQ = '0;
    @(posedge CLK); #1;
    checks++;
    if (STK_PUSH !== 1'b1) begin
      failures++; $display("FAIL mid_push: STK_PUSH=%b expected=1", STK_PUSH);
    end
    #1 RST_N = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({STK_PUSH, STK_POP, GNT, DONE, LEVEL} !== '0) begin
      failures++;
      $display("FAIL mid_reset: push=%b pop=%b gnt=%b done=%b level=%0d expected 0", STK_PUSH, STK_POP, GNT, DONE, LEVEL);
    end
    @(negedge CLK); RST_N = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK); #1;
      checks++;
      if ({DONE, LEVEL} !== 8'b0) begin
        failures++; $display("FAIL after_reset: DONE=%b LEVEL=%0d expected 0", DONE, LEVEL);
      end
    end
    run_txn(2'b11, 2'b00, 2'b10, 2'b01);
  endtask

  initial begin
    test_reset();
    test_idle();
    test_single_push();
    test_push_pop_r1();
    test_contention();
    test_idle();
    test_empty_pop();
    test_fill();
    test_random();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
